// File: rtl/sr_pulse_seq_if.sv
// -----------------------------------------------------------------------------
// sr_pulse_seq_if
// Request/latch bundle between control logic and the SR pulse sequencer.
//   req_valid / req_ready / req_idx / req_op : request handshake
//   s_out / r_out                            : S and R drives, one bit per latch
//   q_in                                     : Q feedback from the latch bank
//   busy / done / err                        : sequencer status
// The master modport is the requester/latch side; the slave is the sequencer.
// -----------------------------------------------------------------------------
interface sr_pulse_seq_if #(
  parameter int N_LATCH = 4,
  parameter int IDX_W   = 2
);
  logic               req_valid;
  logic               req_ready;
  logic [IDX_W-1:0]   req_idx;
  logic               req_op;
  logic [N_LATCH-1:0] s_out;
  logic [N_LATCH-1:0] r_out;
  logic [N_LATCH-1:0] q_in;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output req_valid, req_idx, req_op, q_in,
    input  req_ready, s_out, r_out, busy, done, err
  );

  modport slave (
    input  req_valid, req_idx, req_op, q_in,
    output req_ready, s_out, r_out, busy, done, err
  );
endinterface

// File: rtl/sr_pulse_seq.sv
// -----------------------------------------------------------------------------
// sr_pulse_seq
// Drives the S/R inputs of a bank of N_LATCH SR latches from one request port.
// Every accepted request gives one S or R pulse of PULSE_W cycles, then GAP_W
// dead-time cycles with all S/R low, then a one-cycle CHECK that reports done
// and flags err on a bad index or a Q readback mismatch.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  sr_pulse_seq_if.slave (request handshake, S/R drives, Q feedback,
//        busy/done/err status)
//
// Optional feature (macro SR_SKIP_EN): a valid request whose latch already
// holds the requested value skips PULSE and GAP and completes one cycle after
// accept with err = 0.
//
// s_out, r_out, busy, req_ready and done are registers decoded from the next
// state. err is the registered done qualified with q_in as seen in the CHECK
// cycle itself, so the latch has the full gap to settle before readback.
// -----------------------------------------------------------------------------
module sr_pulse_seq #(
  parameter int N_LATCH = 4,
  parameter int IDX_W   = 2,
  parameter int PULSE_W = 3,
  parameter int GAP_W   = 2
) (
  input  logic          clk,
  input  logic          rst,
  sr_pulse_seq_if.slave bus
);

  localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [CNT_W-1:0]   PULSE_LOAD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0]   GAP_LOAD   = CNT_W'(GAP_W - 1);
  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [N_LATCH-1:0] LAT_ZERO   = {N_LATCH{1'b0}};
  localparam logic [IDX_W-1:0]   IDX_ZERO   = {IDX_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  // Index compares go through int so an IDX_W wider than the latch bank never
  // produces an out-of-range bit select.
  function automatic logic idx_bad(input logic [IDX_W-1:0] idx);
    return (int'(idx) >= N_LATCH);
  endfunction

  function automatic logic q_bit(input logic [N_LATCH-1:0] q,
                                 input logic [IDX_W-1:0]   idx);
    logic b;
    b = 1'b0;
    for (int i = 0; i < N_LATCH; i++) begin
      if (int'(idx) == i) b = q[i];
      else                b = b;
    end
    return b;
  endfunction

  function automatic logic [N_LATCH-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_LATCH-1:0] v;
    for (int i = 0; i < N_LATCH; i++) begin
      v[i] = (int'(idx) == i);
    end
    return v;
  endfunction

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic               r_op, w_op_nxt;
  logic               r_bad, w_bad_nxt;
  logic               r_skip, w_skip_nxt;
  logic [N_LATCH-1:0] r_s_out, r_r_out;
  logic [N_LATCH-1:0] w_drive, w_s_nxt, w_r_nxt;
  logic               r_busy, r_ready, r_done;

  // Next-state, counter and capture logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_op_nxt    = r_op;
    w_bad_nxt   = r_bad;
    w_skip_nxt  = r_skip;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid && r_ready) begin
          w_idx_nxt  = bus.req_idx;
          w_op_nxt   = bus.req_op;
          w_skip_nxt = 1'b0;
          w_cnt_nxt  = CNT_ZERO;
          if (idx_bad(bus.req_idx)) begin
            w_bad_nxt   = 1'b1;
            w_state_nxt = ST_CHECK;
          end else begin
            w_bad_nxt = 1'b0;
`ifdef SR_SKIP_EN
            if (q_bit(bus.q_in, bus.req_idx) == bus.req_op) begin
              w_skip_nxt  = 1'b1;
              w_state_nxt = ST_CHECK;
            end else begin
              w_state_nxt = ST_PULSE;
              w_cnt_nxt   = PULSE_LOAD;
            end
`else
            w_state_nxt = ST_PULSE;
            w_cnt_nxt   = PULSE_LOAD;
`endif
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PULSE: begin
        if (r_cnt == CNT_ZERO) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = GAP_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_GAP: begin
        if (r_cnt == CNT_ZERO) begin
          w_state_nxt = ST_CHECK;
        end else begin
          w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_CHECK: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase

    // Only one bit of one bank can ever be driven, and only in PULSE.
    w_drive = (w_state_nxt == ST_PULSE) ? onehot(w_idx_nxt) : LAT_ZERO;
    w_s_nxt = w_op_nxt ? w_drive : LAT_ZERO;
    w_r_nxt = w_op_nxt ? LAT_ZERO : w_drive;
  end

  // State, capture and registered output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= CNT_ZERO;
      r_idx   <= IDX_ZERO;
      r_op    <= 1'b0;
      r_bad   <= 1'b0;
      r_skip  <= 1'b0;
      r_s_out <= LAT_ZERO;
      r_r_out <= LAT_ZERO;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_op    <= w_op_nxt;
      r_bad   <= w_bad_nxt;
      r_skip  <= w_skip_nxt;
      r_s_out <= w_s_nxt;
      r_r_out <= w_r_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_ready <= (w_state_nxt == ST_IDLE);
      r_done  <= (w_state_nxt == ST_CHECK);
    end
  end

  assign bus.s_out     = r_s_out;
  assign bus.r_out     = r_r_out;
  assign bus.busy      = r_busy;
  assign bus.req_ready = r_ready;
  assign bus.done      = r_done;
  // A skipped request already matched at accept, so it never reports err.
  assign bus.err       = r_done & (r_bad | (~r_skip & (q_bit(bus.q_in, r_idx) != r_op)));

endmodule

// File: tb/tb_sr_pulse_seq.sv
// -----------------------------------------------------------------------------
// tb_sr_pulse_seq
// Bench for sr_pulse_seq with N_LATCH=4, IDX_W=3 (so idx 4..7 are bad),
// PULSE_W=3, GAP_W=2. A latch bank model feeds q_in from the DUT's S/R drives
// (with an optional stuck-at-0 mask). A transaction-level reference tracks the
// age of the request in flight and derives every output from it; a compare
// process checks all outputs on each falling edge. Directed sequences pin the
// reference with hand-computed literals, then a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_sr_pulse_seq;
  localparam int NL = 4;
  localparam int IW = 3;
  localparam int PW = 3;
  localparam int GW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sr_pulse_seq_if #(.N_LATCH(NL), .IDX_W(IW)) bus ();

  sr_pulse_seq #(.N_LATCH(NL), .IDX_W(IW), .PULSE_W(PW), .GAP_W(GW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Latch bank model: S sets, R resets, stuck bits hold 0.
  logic [NL-1:0] q_m   = 4'b0000;
  logic [NL-1:0] stuck = 4'b0000;
  always @(posedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (stuck[i])          q_m[i] <= 1'b0;
      else if (bus.s_out[i]) q_m[i] <= 1'b1;
      else if (bus.r_out[i]) q_m[i] <= 1'b0;
    end
  end
  assign bus.q_in = q_m;

  // Reference: a request lives for m_len cycles after accept; age 1 is the
  // first cycle after the accept edge.
  logic       m_inflight = 1'b0;
  int         m_age = 0;
  int         m_len = 0;
  logic [2:0] m_idx = 3'd0;
  logic       m_op = 1'b0;
  logic       m_bad = 1'b0;
  logic       m_skip = 1'b0;

  // Reference update on each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m_inflight = 1'b0;
    end else if (m_inflight) begin
      if (m_age == m_len) m_inflight = 1'b0;
      else                m_age = m_age + 1;
    end else if (bus.req_valid) begin
      m_idx  = bus.req_idx;
      m_op   = bus.req_op;
      m_bad  = (bus.req_idx >= 3'd4);
      m_skip = 1'b0;
`ifdef SR_SKIP_EN
      if (!m_bad && (q_m[m_idx[1:0]] == m_op)) m_skip = 1'b1;
`endif
      m_len      = (m_bad || m_skip) ? 1 : PW + GW + 1;
      m_age      = 1;
      m_inflight = 1'b1;
    end
  end

  // Compare all outputs against the reference on every falling edge.
  always @(negedge clk) begin
    logic [NL-1:0] es, er;
    logic ed, ee, eb, ey;
    if (chk_en) begin
      es = 4'b0000; er = 4'b0000; ed = 1'b0; ee = 1'b0; eb = 1'b0; ey = 1'b1;
      if (m_inflight) begin
        eb = 1'b1;
        ey = 1'b0;
        if (!m_bad && !m_skip && m_age <= PW) begin
          if (m_op) es = 4'b0001 << m_idx[1:0];
          else      er = 4'b0001 << m_idx[1:0];
        end
        if (m_age == m_len) begin
          ed = 1'b1;
          ee = m_bad | (!m_skip & (q_m[m_idx[1:0]] != m_op));
        end
      end
      chk("s_out", bus.s_out, es);
      chk("r_out", bus.r_out, er);
      chk("done", bus.done, ed);
      chk("err", bus.err, ee);
      chk("busy", bus.busy, eb);
      chk("req_ready", bus.req_ready, ey);
      chk("s_and_r", bus.s_out & bus.r_out, 32'd0);
      chk("onehot", ($countones(bus.s_out | bus.r_out) <= 1), 32'd1);
    end
  end

  logic [NL-1:0] tr_s [1:8];
  logic [NL-1:0] tr_r [1:8];
  logic          tr_d [1:8];
  logic          tr_e [1:8];

  // Present a request, wait (bounded) for acceptance, optionally keep valid high.
  task automatic issue(input logic [2:0] idx, input logic op, input logic keep);
    int w;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_idx   = idx;
    bus.req_op    = op;
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("accept_timeout", (w < 50), 32'd1);
    @(posedge clk);
    #1;
    if (!keep) bus.req_valid = 1'b0;
  endtask

  // Issue a request and record the eight cycles that follow the accept edge.
  task automatic issue_trace(input logic [2:0] idx, input logic op);
    issue(idx, op, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      tr_s[k] = bus.s_out;
      tr_r[k] = bus.r_out;
      tr_d[k] = bus.done;
      tr_e[k] = bus.err;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_idx   = 3'd0;
    bus.req_op    = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", bus.req_ready, 32'd1);
    chk("reset_busy", bus.busy, 32'd0);
    chk("reset_s", bus.s_out, 32'd0);

    // Set idx 1 from Q=0.
    issue_trace(3'd1, 1'b1);
    for (int k = 1; k <= 3; k++) chk("set1_s", tr_s[k], 32'h2);
    chk("set1_gap", {tr_s[4], tr_s[5], tr_r[4], tr_r[5]}, 32'd0);
    chk("set1_done", {tr_d[5], tr_d[6], tr_d[7]}, 32'b010);
    chk("set1_err", tr_e[6], 32'd0);
    chk("set1_q", q_m[1], 32'd1);

    // Reset idx 1 right after.
    issue_trace(3'd1, 1'b0);
    for (int k = 1; k <= 3; k++) chk("rst1_r", tr_r[k], 32'h2);
    for (int k = 1; k <= 8; k++) chk("rst1_s", tr_s[k], 32'd0);
    chk("rst1_done", tr_d[6], 32'd1);
    chk("rst1_q", q_m[1], 32'd0);

    // Held valid, alternating idx 0 / idx 3.
    issue(3'd0, 1'b1, 1'b1);
    issue(3'd3, 1'b1, 1'b1);
    issue(3'd0, 1'b0, 1'b1);
    issue(3'd3, 1'b0, 1'b1);
    issue(3'd0, 1'b1, 1'b1);
    issue(3'd3, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    chk("held_q", q_m, 32'h9);

    // Bad index.
    issue_trace(3'd5, 1'b1);
    chk("bad_done", {tr_d[1], tr_d[2]}, 32'b10);
    chk("bad_err", tr_e[1], 32'd1);
    chk("bad_nopulse", tr_s[1] | tr_r[1] | tr_s[2] | tr_r[2], 32'd0);

    // Latch 2 stuck at 0.
    stuck = 4'b0100;
    issue_trace(3'd2, 1'b1);
    for (int k = 1; k <= 3; k++) chk("stuck_s", tr_s[k], 32'h4);
    chk("stuck_done", tr_d[6], 32'd1);
    chk("stuck_err", tr_e[6], 32'd1);
    stuck = 4'b0000;

    // Reset during the second pulse cycle.
    issue(3'd2, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_pulse_s", bus.s_out, 32'h4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_s", bus.s_out, 32'd0);
    chk("mid_rst_ready", bus.req_ready, 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("mid_rst_nodone", bus.done, 32'd0);
    end

    // Request matching current Q (q[1] = 0, reset op).
    issue_trace(3'd1, 1'b0);
`ifdef SR_SKIP_EN
    chk("skip_done", tr_d[1], 32'd1);
    chk("skip_err", tr_e[1], 32'd0);
    chk("skip_nopulse", tr_s[1] | tr_r[1], 32'd0);
`else
    chk("noskip_r", tr_r[1], 32'h2);
    chk("noskip_done", tr_d[6], 32'd1);
`endif

    // Randomized phase.
    for (int n = 0; n < 150; n++) begin
      logic [2:0] ridx;
      ridx = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
      if (!bus.busy) stuck = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      issue(ridx, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 15) == 0) begin
        repeat ($urandom_range(0, 5)) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end else begin
        repeat ($urandom_range(0, 8)) @(negedge clk);
      end
    end
    bus.req_valid = 1'b0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/sr_pulse_seq.md
Name: sr_pulse_seq

Overview:
- Sequencer that drives the S/R inputs of a bank of N_LATCH external SR latches from a single request port.
- Each accepted request produces one clean set or reset pulse of fixed width, followed by a dead-time gap with S=R=0, then a readback check of Q.
- Guarantees that S and R are never high together and that no two pulses overlap.
- Sits between control logic and the sr_latch instances, replacing hand-timed S/R stimulus.

Parameters:
- N_LATCH, 4, number of latches driven (1..16).
- IDX_W, 2, width of req_idx; must satisfy 2**IDX_W >= N_LATCH.
- PULSE_W, 3, cycles S or R is held high (>=1).
- GAP_W, 2, dead-time cycles with all S/R low after a pulse (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_idx  input  IDX_W  target latch index.
- req_op  input  1  1 = set (S pulse), 0 = reset (R pulse).
- s_out  output  N_LATCH  S inputs to the latches, one bit per latch.
- r_out  output  N_LATCH  R inputs to the latches, one bit per latch.
- q_in  input  N_LATCH  Q feedback from the latches.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a request completes.
- err  output  1  one-cycle pulse, qualified by done: bad index or Q mismatch.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - s_out = r_out = 0; done = err = 0; busy = 0; req_ready = 1.
  - FSM = IDLE; counter = 0; captured idx/op = 0.
- Reset mid-operation: asserting rst in any state forces all reset values on the next edge. A pulse in flight is truncated and no done is produced.
- FSM states: IDLE, PULSE, GAP, CHECK.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, capture req_idx and req_op.
  - If req_idx >= N_LATCH, go to CHECK with a bad-index flag set; no pulse is issued.
  - Otherwise go to PULSE and load counter = PULSE_W-1.
- PULSE:
  - Drive bit idx of s_out if op=1, else bit idx of r_out. All other bits are 0.
  - Counter decrements each cycle. At 0, go to GAP and load counter = GAP_W-1.
  - The pulse is high for exactly PULSE_W cycles, starting the cycle after acceptance.
- GAP: s_out = r_out = 0. When counter reaches 0, go to CHECK.
- CHECK (one cycle):
  - done = 1.
  - err = 1 if the bad-index flag is set, or if q_in[idx] != op.
  - Next state is IDLE.
- Latency: from the accept edge to done high is PULSE_W + GAP_W + 1 cycles.
- Back-to-back: req_ready returns high the cycle after CHECK. The next pulse therefore starts at least GAP_W+2 cycles after the previous pulse fell.
- req_ready is 0 in PULSE, GAP and CHECK. Requests presented then are not accepted; the requester must hold req_valid.
- Invariant: (s_out & r_out) == 0 and popcount(s_out | r_out) <= 1 in every cycle.
- q_in is sampled only in CHECK. It is treated as synchronous to clk; any synchronizing flops belong to the integrator.
- Counters are sized to max(PULSE_W, GAP_W), with no wrap-around beyond the loaded value.

Optional Feature:
- Macro: SR_SKIP_EN.
- When defined: at accept, if req_idx is valid and q_in[req_idx] == req_op already, skip PULSE and GAP and go directly to CHECK. done follows 1 cycle after accept, with err = 0.
- When undefined: every valid request issues a full pulse and gap regardless of the current Q.

Test Plan:
- Reset, then set on idx 1 (PULSE_W=3, GAP_W=2), with the model latch at Q=0 -> s_out=4'b0010 for exactly 3 cycles, then 2 cycles of zero, done=1 and err=0 at accept+6, Q[1]=1.
- Reset on idx 1 immediately after the previous completion -> r_out=4'b0010 for 3 cycles, s_out never high during it; done at accept+6, Q[1]=0.
- req_valid held continuously with alternating set/reset to idx 0 and idx 3 -> req_ready low during PULSE/GAP/CHECK, each request served in order, S&R never overlap, at least 4 idle S/R cycles between pulses.
- req_idx = 5 with N_LATCH=4, IDX_W=3 -> no pulse on any bit, done=1 and err=1 at accept+1.
- Model latch stuck at 0, set request -> full pulse issued, then done=1 with err=1.
- rst asserted on the 2nd PULSE cycle -> s_out=0 on the next edge, no done, req_ready=1. With SR_SKIP_EN and Q already 1, a set request gives no pulse and done=1, err=0 at accept+1.
